// File: rtl/dca_matrix_lsu_areq_gen.sv
// Multi-row AXI address-request generator for the DCA matrix LSU: walks a strided matrix and
// emits one INCR burst request per chunk. Define DCA_LSU_AREQ_BOUNDARY_SPLIT_EN to split bursts at 4 KB.
module dca_matrix_lsu_areq_gen #(
   parameter int BW_ADDR         = 32,
   parameter int BW_DATA         = 32,
   parameter int BW_STRIDE       = 24,
   parameter int BW_NUM          = 16,
   parameter int MAX_BURST_LEN   = 16,
   parameter int MAX_OUTSTANDING = 4,
   localparam int BW_OUT         = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 clk,
   input  logic                 rstnn,
   input  logic                 inst_valid,
   output logic                 inst_ready,
   input  logic                 inst_is_write,
   input  logic [BW_ADDR-1:0]   inst_addr,
   input  logic [BW_STRIDE-1:0] inst_stride,
   input  logic [BW_NUM-1:0]    inst_num_row_m1,
   input  logic [BW_NUM-1:0]    inst_row_beats_m1,
   output logic                 req_valid,
   input  logic                 req_ready,
   output logic                 req_is_write,
   output logic [BW_ADDR-1:0]   req_addr,
   output logic [7:0]           req_len,
   output logic [2:0]           req_size,
   output logic [1:0]           req_burst,
   output logic                 req_last,
   input  logic                 rsp_done,
   output logic                 busy,
   output logic                 done,
   output logic [BW_OUT-1:0]    outstanding,
   output logic                 err_underflow
);
   localparam int BYTES    = BW_DATA / 8;
   localparam int SIZE     = $clog2(BYTES);
   localparam int BW_BEATS = BW_NUM + 1;
   localparam logic [BW_ADDR-1:0]  ADDR_MASK = ~(BW_ADDR'(BYTES - 1));
   localparam logic [BW_BEATS-1:0] MAX_BL    = BW_BEATS'(MAX_BURST_LEN);
   localparam logic [BW_OUT-1:0]   OUT_MAX   = BW_OUT'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
   state_t state, state_next;

   logic                 is_write_reg;
   logic [BW_ADDR-1:0]   stride_reg;
   logic [BW_ADDR-1:0]   row_addr_reg;
   logic [BW_ADDR-1:0]   cur_addr_reg;
   logic [BW_NUM-1:0]    rows_left_reg;
   logic [BW_BEATS-1:0]  beats_left_reg;
   logic [BW_BEATS-1:0]  row_beats_reg;

   logic                 accept;
   logic                 hs;
   logic                 load_req;
   logic                 rsp_dec;
   logic [BW_ADDR-1:0]   src_addr;
   logic [BW_BEATS-1:0]  src_beats;
   logic                 src_last;
   logic [BW_BEATS-1:0]  burst_beats;
   logic                 burst_last;
   logic [BW_BEATS-1:0]  sent_beats;
   logic [BW_BEATS-1:0]  beats_after;
   logic [BW_ADDR-1:0]   next_row_addr;

   assign accept    = inst_valid & inst_ready;
   assign hs        = req_valid & req_ready;
   assign rsp_dec   = rsp_done & (outstanding != '0);
   assign req_size  = 3'(SIZE);
   assign req_burst = 2'b01;

   // On accept the first burst is computed straight from the instruction so it is valid next cycle.
   assign src_addr  = accept ? (inst_addr & ADDR_MASK) : cur_addr_reg;
   assign src_beats = accept ? (BW_BEATS'(inst_row_beats_m1) + BW_BEATS'(1)) : beats_left_reg;
   assign src_last  = accept ? (inst_num_row_m1 == '0) : (rows_left_reg == '0);

`ifdef DCA_LSU_AREQ_BOUNDARY_SPLIT_EN
   logic [12:0] page_room;
   always_comb begin
      page_room   = (13'd4096 - {1'b0, src_addr[11:0]}) >> SIZE;
      burst_beats = (src_beats > MAX_BL) ? MAX_BL : src_beats;
      if (BW_BEATS'(page_room) < burst_beats)
         burst_beats = BW_BEATS'(page_room);
   end
`else
   always_comb begin
      burst_beats = (src_beats > MAX_BL) ? MAX_BL : src_beats;
   end
`endif

   assign burst_last    = src_last & (burst_beats == src_beats);
   assign load_req      = accept | ((state == GEN) & ~req_valid & (outstanding != OUT_MAX));
   assign sent_beats    = BW_BEATS'(req_len) + BW_BEATS'(1);
   assign beats_after   = beats_left_reg - sent_beats;
   assign next_row_addr = row_addr_reg + stride_reg;

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      inst_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid) state_next = GEN;
         end
         GEN: begin
            busy = 1'b1;
            if (hs && req_last) state_next = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (outstanding == '0) begin
               done       = 1'b1;
               inst_ready = 1'b1;
               state_next = inst_valid ? GEN : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         is_write_reg   <= 1'b0;
         stride_reg     <= '0;
         row_addr_reg   <= '0;
         cur_addr_reg   <= '0;
         rows_left_reg  <= '0;
         beats_left_reg <= '0;
         row_beats_reg  <= '0;
      end else if (accept) begin
         is_write_reg   <= inst_is_write;
         stride_reg     <= BW_ADDR'(inst_stride) & ADDR_MASK;
         row_addr_reg   <= src_addr;
         cur_addr_reg   <= src_addr;
         rows_left_reg  <= inst_num_row_m1;
         beats_left_reg <= src_beats;
         row_beats_reg  <= src_beats;
      end else if (hs) begin
         if (beats_after == '0) begin
            if (rows_left_reg != '0) begin
               row_addr_reg   <= next_row_addr;
               cur_addr_reg   <= next_row_addr;
               beats_left_reg <= row_beats_reg;
               rows_left_reg  <= rows_left_reg - 1'b1;
            end
         end else begin
            cur_addr_reg   <= cur_addr_reg + (BW_ADDR'(sent_beats) << SIZE);
            beats_left_reg <= beats_after;
         end
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         req_valid    <= 1'b0;
         req_is_write <= 1'b0;
         req_addr     <= '0;
         req_len      <= '0;
         req_last     <= 1'b0;
      end else if (load_req) begin
         req_valid    <= 1'b1;
         req_is_write <= accept ? inst_is_write : is_write_reg;
         req_addr     <= src_addr;
         req_len      <= 8'(burst_beats - BW_BEATS'(1));
         req_last     <= burst_last;
      end else if (hs) begin
         req_valid <= 1'b0;
         req_last  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         outstanding   <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (hs && !rsp_dec)      outstanding <= outstanding + 1'b1;
         else if (!hs && rsp_dec) outstanding <= outstanding - 1'b1;
         if (rsp_done && outstanding == '0) err_underflow <= 1'b1;
      end
   end
endmodule
